// File: rtl/gray_to_binary_tracker.sv
// gray_to_binary_tracker
// Receive side of a Gray-coded position bus. It decodes each valid Gray sample
// to binary and checks that the sample is a single legal step from the
// previous valid sample. It reports the direction of travel, flags illegal
// jumps and keeps a saturating fault count.
//
// Pipeline (latency 2, full throughput):
//   edge k   : G/GV captured into g_reg/gv_reg
//   edge k+1 : Gray decoded into bin_reg/bin_v_reg
//   edge k+2 : classified against the reference, outputs registered
module gray_to_binary_tracker #(
  parameter int W   = 4,
  parameter int ECW = 8
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [W-1:0]   G,
  input  logic           GV,
  output logic [W-1:0]   BIN,
  output logic           BV,
  output logic           STEP,
  output logic           DIR,
  output logic           ERR,
  output logic [ECW-1:0] ERRCNT,
  output logic           LOCK
);

  // INIT and FAULT both accept the next valid sample as a fresh reference.
  // They are kept as separate states so that a debugger can tell "never
  // locked" apart from "lost lock".
  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [W-1:0]   DIFF_UP   = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]   DIFF_DOWN = {W{1'b1}};
  localparam logic [W-1:0]   DIFF_HOLD = {W{1'b0}};
  localparam logic [ECW-1:0] CNT_MAX   = {ECW{1'b1}};
  localparam logic [ECW-1:0] CNT_ONE   = {{(ECW-1){1'b0}}, 1'b1};

  // Stage 0: raw capture of the bus.
  logic [W-1:0] g_reg;
  logic         gv_reg;

  // Stage 1: decoded binary sample.
  logic [W-1:0] bin_dec;
  logic [W-1:0] bin_reg;
  logic         bin_v_reg;

  // Stage 2: classification state.
  state_t       state_reg;
  logic [W-1:0] ref_reg;

  // Classification of the stage-1 sample against the reference.
  logic [W-1:0] diff;
  logic         is_up;
  logic         is_down;
  logic         is_hold;

  // Capture the Gray input and its valid. Reset drops any sample in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      g_reg  <= '0;
      gv_reg <= 1'b0;
    end else begin
      g_reg  <= G;
      gv_reg <= GV;
    end
  end

  // Each binary bit is the parity of all Gray bits from itself up to the MSB.
  // Writing it as a parity over a slice avoids a self-referencing bit chain
  // in bin_dec.
  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_decode
      assign bin_dec[gi] = ^g_reg[W-1:gi];
    end
  endgenerate

  // Register the decoded binary sample and its valid.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bin_reg   <= '0;
      bin_v_reg <= 1'b0;
    end else begin
      bin_reg   <= bin_dec;
      bin_v_reg <= gv_reg;
    end
  end

  // The modular difference decides the step: +1 is up, -1 (all ones) is down,
  // 0 is a hold, and anything else is an illegal jump. Two Gray codes that
  // differ in only one bit can still be far apart in the sequence, which is
  // why the check uses the binary difference and not the Gray Hamming distance.
  always_comb begin
    diff    = bin_reg - ref_reg;
    is_up   = (diff == DIFF_UP);
    is_down = (diff == DIFF_DOWN);
    is_hold = (diff == DIFF_HOLD);
  end

  // Tracking FSM with registered outputs. Flags are pulses qualified by BV.
  // DIR and BIN hold their last values between pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= ST_INIT;
      ref_reg   <= '0;
      BIN       <= '0;
      BV        <= 1'b0;
      STEP      <= 1'b0;
      DIR       <= 1'b0;
      ERR       <= 1'b0;
      ERRCNT    <= '0;
      LOCK      <= 1'b0;
    end else begin
      BV   <= bin_v_reg;
      STEP <= 1'b0;
      ERR  <= 1'b0;
      if (bin_v_reg) begin
        // Every accepted sample becomes the new reference, even a faulty one,
        // so that the following sample resynchronises to it.
        BIN     <= bin_reg;
        ref_reg <= bin_reg;
        case (state_reg)
          ST_TRACK: begin
            if (is_up) begin
              STEP <= 1'b1;
              DIR  <= 1'b1;
            end else if (is_down) begin
              STEP <= 1'b1;
              DIR  <= 1'b0;
            end else if (!is_hold) begin
              ERR       <= 1'b1;
              LOCK      <= 1'b0;
              state_reg <= ST_FAULT;
              if (ERRCNT != CNT_MAX) begin
                ERRCNT <= ERRCNT + CNT_ONE;
              end
            end
          end
          default: begin
            // INIT or FAULT: take the sample as the reference without
            // classifying it.
            LOCK      <= 1'b1;
            state_reg <= ST_TRACK;
          end
        endcase
      end
    end
  end

endmodule
